// File: rtl/dram_responder.sv
// rtl/dram_responder.sv - DRAM-side data-memory responder with fixed wait states
module dram_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 65536,
  parameter int LATENCY    = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] AR_to_DRAM,
  input  logic [DATA_WIDTH-1:0] MDR_to_DRAM,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic [DATA_WIDTH-1:0] DRAM_to_MDR,
  output logic                  mem_busy,
  output logic                  mem_done,
  output logic                  mem_error
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic             w_can_accept;
  logic             w_accept;
  logic             w_conflict;
  logic             w_in_range;
  logic             w_last;
  logic             w_commit;
  logic [IDX_W-1:0] w_idx;

  // A new request may be taken in IDLE and in the DONE cycle (back-to-back)
  always_comb begin
    w_can_accept = (r_state != BUSY);
    w_accept     = w_can_accept && (mem_read ^ mem_write);
    w_conflict   = w_can_accept && mem_read && mem_write;
    w_in_range   = ({1'b0, r_addr} < DEPTH_L);
    w_last       = (r_state == BUSY) && (r_cnt == 4'd0);
    w_commit     = w_last && r_write && w_in_range;
    w_idx        = r_addr[IDX_W-1:0];
  end

  // Storage array; not reset, and a write commits only on the completion edge
  always_ff @(posedge clock) begin
    if (w_commit) begin
      r_mem[w_idx] <= r_data;
    end
  end

  // Request FSM with registered status outputs and read data
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_addr      <= '0;
      r_data      <= '0;
      r_write     <= 1'b0;
      DRAM_to_MDR <= '0;
      mem_busy    <= 1'b0;
      mem_done    <= 1'b0;
      mem_error   <= 1'b0;
    end else begin
      mem_done  <= 1'b0;
      mem_error <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_conflict) begin
            r_state   <= IDLE;
            mem_busy  <= 1'b0;
            mem_error <= 1'b1;
          end else if (w_accept) begin
            r_state  <= BUSY;
            r_cnt    <= CNT_INIT;
            r_addr   <= AR_to_DRAM;
            r_data   <= MDR_to_DRAM;
            r_write  <= mem_write;
            mem_busy <= 1'b1;
          end else begin
            r_state  <= IDLE;
            mem_busy <= 1'b0;
          end
        end
        BUSY: begin
          if (r_cnt == 4'd0) begin
            r_state   <= DONE;
            mem_busy  <= 1'b0;
            mem_done  <= 1'b1;
            mem_error <= !w_in_range;
            if (!r_write) begin
              DRAM_to_MDR <= w_in_range ? r_mem[w_idx] : '0;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state  <= IDLE;
          mem_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_responder.sv
// tb/tb_dram_responder.sv - directed self-checking bench for dram_responder
module tb_dram_responder;

  logic        clock;
  logic        reset_n;
  logic [15:0] AR_to_DRAM;
  logic [7:0]  MDR_to_DRAM;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  DRAM_to_MDR;
  logic        mem_busy;
  logic        mem_done;
  logic        mem_error;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int busy_cnt = 0;

  dram_responder #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(8),
    .DEPTH(256),
    .LATENCY(2)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .AR_to_DRAM(AR_to_DRAM),
    .MDR_to_DRAM(MDR_to_DRAM),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .DRAM_to_MDR(DRAM_to_MDR),
    .mem_busy(mem_busy),
    .mem_done(mem_done),
    .mem_error(mem_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // count pulses as seen at each rising edge
  always @(posedge clock) begin
    if (mem_done) done_cnt++;
    if (mem_busy) busy_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // full request: returns in the DONE cycle, checking the busy window on the way
  task automatic op(input string tag, input logic wr, input logic [15:0] addr,
                    input logic [7:0] data, input logic exp_err);
    AR_to_DRAM  = addr;
    MDR_to_DRAM = data;
    mem_write   = wr;
    mem_read    = !wr;
    step();
    mem_write = 1'b0;
    mem_read  = 1'b0;
    chk({tag, "_busy1"}, {31'b0, mem_busy}, 32'd1);
    chk({tag, "_done1"}, {31'b0, mem_done}, 32'd0);
    step();
    chk({tag, "_busy2"}, {31'b0, mem_busy}, 32'd1);
    step();
    chk({tag, "_done"}, {31'b0, mem_done}, 32'd1);
    chk({tag, "_busy_done"}, {31'b0, mem_busy}, 32'd0);
    chk({tag, "_err"}, {31'b0, mem_error}, {31'b0, exp_err});
  endtask

  initial begin
    reset_n = 1'b0; AR_to_DRAM = '0; MDR_to_DRAM = '0; mem_read = 1'b0; mem_write = 1'b0;
    step(); step();
    chk("rst_busy", {31'b0, mem_busy}, 32'd0);
    chk("rst_done", {31'b0, mem_done}, 32'd0);
    chk("rst_err",  {31'b0, mem_error}, 32'd0);
    chk("rst_data", {24'b0, DRAM_to_MDR}, 32'h0);
    reset_n = 1'b1;
    step();

    // write then read, busy exactly two cycles
    busy_cnt = 0;
    op("wr10", 1'b1, 16'h0010, 8'hA5, 1'b0);
    chk("wr10_busycnt", busy_cnt, 32'd2);
    chk("wr10_data_unchanged", {24'b0, DRAM_to_MDR}, 32'h0);
    step();
    chk("wr10_idle_done", {31'b0, mem_done}, 32'd0);
    op("rd10", 1'b0, 16'h0010, 8'h00, 1'b0);
    chk("rd10_data", {24'b0, DRAM_to_MDR}, 32'hA5);
    step();

    // back-to-back: read accepted at the DONE edge, BUSY-time request ignored
    done_cnt = 0;
    op("wr11", 1'b1, 16'h0011, 8'h3E, 1'b0);
    AR_to_DRAM = 16'h0011; mem_read = 1'b1;
    step();
    mem_read = 1'b0;
    chk("b2b_busy", {31'b0, mem_busy}, 32'd1);
    chk("b2b_done", {31'b0, mem_done}, 32'd0);
    AR_to_DRAM = 16'h0010; mem_read = 1'b1;
    step();
    mem_read = 1'b0;
    chk("b2b_busy2", {31'b0, mem_busy}, 32'd1);
    step();
    chk("b2b_rd_done", {31'b0, mem_done}, 32'd1);
    chk("b2b_rd_data", {24'b0, DRAM_to_MDR}, 32'h3E);
    step();
    chk("b2b_idle_busy", {31'b0, mem_busy}, 32'd0);
    step();
    chk("b2b_idle_done", {31'b0, mem_done}, 32'd0);
    chk("b2b_done_count", done_cnt, 32'd2);

    // conflicting request
    done_cnt = 0;
    AR_to_DRAM = 16'h0010; MDR_to_DRAM = 8'hFF; mem_read = 1'b1; mem_write = 1'b1;
    step();
    mem_read = 1'b0; mem_write = 1'b0;
    chk("cf_err", {31'b0, mem_error}, 32'd1);
    chk("cf_busy", {31'b0, mem_busy}, 32'd0);
    chk("cf_data", {24'b0, DRAM_to_MDR}, 32'h3E);
    step();
    chk("cf_err_off", {31'b0, mem_error}, 32'd0);
    chk("cf_no_done", done_cnt, 32'd0);
    op("cf_rd10", 1'b0, 16'h0010, 8'h00, 1'b0);
    chk("cf_mem_kept", {24'b0, DRAM_to_MDR}, 32'hA5);
    step();

    // out-of-range access with DEPTH=256
    op("wr00", 1'b1, 16'h0000, 8'h5A, 1'b0);
    step();
    op("oor_wr", 1'b1, 16'h0100, 8'h3C, 1'b1);
    step();
    chk("oor_err_off", {31'b0, mem_error}, 32'd0);
    op("oor_rd", 1'b0, 16'h0100, 8'h00, 1'b1);
    chk("oor_rd_data", {24'b0, DRAM_to_MDR}, 32'h00);
    step();
    op("rd00", 1'b0, 16'h0000, 8'h00, 1'b0);
    chk("rd00_data", {24'b0, DRAM_to_MDR}, 32'h5A);
    step();

    // aborted write via asynchronous reset mid-BUSY
    op("wr20", 1'b1, 16'h0020, 8'h11, 1'b0);
    step();
    op("rd20", 1'b0, 16'h0020, 8'h00, 1'b0);
    chk("rd20_data", {24'b0, DRAM_to_MDR}, 32'h11);
    step();
    AR_to_DRAM = 16'h0020; MDR_to_DRAM = 8'h77; mem_write = 1'b1;
    step();
    mem_write = 1'b0;
    step();
    chk("ab_busy_pre", {31'b0, mem_busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("ab_async_busy", {31'b0, mem_busy}, 32'd0);
    chk("ab_async_done", {31'b0, mem_done}, 32'd0);
    chk("ab_async_data", {24'b0, DRAM_to_MDR}, 32'h00);
    step();
    reset_n = 1'b1;
    step();
    chk("ab_idle_busy", {31'b0, mem_busy}, 32'd0);
    chk("ab_idle_done", {31'b0, mem_done}, 32'd0);
    op("ab_rd20", 1'b0, 16'h0020, 8'h00, 1'b0);
    chk("ab_rd20_data", {24'b0, DRAM_to_MDR}, 32'h11);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
